// File: rtl/vga_display_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : vga_display_engine                                              |
// | Brief  : Parametrised VGA timing generator with N-layer pixel overlay,   |
// |          latency-aligned blanking and sync outputs.                      |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module vga_display_engine #(
  parameter int              CLK_DIV  = 4,
  parameter int              CW       = 4,
  parameter int              NL       = 2,
  parameter int              CNT_W    = 10,
  parameter int              H_ACT    = 640,
  parameter int              H_FP     = 16,
  parameter int              H_SYNC   = 96,
  parameter int              H_BP     = 48,
  parameter int              V_ACT    = 480,
  parameter int              V_FP     = 10,
  parameter int              V_SYNC   = 2,
  parameter int              V_BP     = 33,
  parameter logic            HS_POL   = 1'b0,
  parameter logic            VS_POL   = 1'b0,
  parameter int              PIX_LAT  = 2,
  parameter logic [3*CW-1:0] BG_COLOR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NL-1:0]        layer_en,
  input  logic [NL-1:0]        layer_hit,
  input  logic [NL*3*CW-1:0]   layer_pix,
  output logic [CNT_W-1:0]     h_cnt,
  output logic [CNT_W-1:0]     v_cnt,
  output logic                 req_valid,
  output logic                 pix_tick,
  output logic                 frame_start,
  output logic [CW-1:0]        vga_r,
  output logic [CW-1:0]        vga_g,
  output logic [CW-1:0]        vga_b,
  output logic                 hsync,
  output logic                 vsync
);

  localparam int HT    = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VT - 1);

  // Region bounds kept one bit wider so an end bound equal to HT/VT still fits.
  localparam logic [CNT_W:0] H_ACT_C    = (CNT_W+1)'(H_ACT);
  localparam logic [CNT_W:0] V_ACT_C    = (CNT_W+1)'(V_ACT);
  localparam logic [CNT_W:0] HS_START_C = (CNT_W+1)'(H_ACT + H_FP);
  localparam logic [CNT_W:0] HS_END_C   = (CNT_W+1)'(H_ACT + H_FP + H_SYNC);
  localparam logic [CNT_W:0] VS_START_C = (CNT_W+1)'(V_ACT + V_FP);
  localparam logic [CNT_W:0] VS_END_C   = (CNT_W+1)'(V_ACT + V_FP + V_SYNC);

  // Reject parameter sets the counters or pipe cannot represent.
  if (((HT - 1) >> CNT_W) != 0) begin : g_chk_ht
    $error("vga_display_engine: HT-1 does not fit in CNT_W bits");
  end
  if (((VT - 1) >> CNT_W) != 0) begin : g_chk_vt
    $error("vga_display_engine: VT-1 does not fit in CNT_W bits");
  end
  if (PIX_LAT < 1) begin : g_chk_lat
    $error("vga_display_engine: PIX_LAT must be at least 1");
  end
  if (CLK_DIV < 1) begin : g_chk_div
    $error("vga_display_engine: CLK_DIV must be at least 1");
  end
  if (NL < 1) begin : g_chk_nl
    $error("vga_display_engine: NL must be at least 1");
  end

  // Pipe entry: {valid, hsync active, vsync active}; all-zero means blank, syncs idle.
  logic [DIV_W-1:0]            div_q, div_d;
  logic                        tick_d;
  logic                        pix_tick_q;
  logic [CNT_W-1:0]            h_q, h_d, v_q, v_d;
  logic                        frame_start_q, frame_start_d;
  logic [NL-1:0]               en_q, en_d;
  logic [PIX_LAT-1:0][2:0]     pipe_q, pipe_d;
  logic [3*CW-1:0]             rgb_q, rgb_d;
  logic                        hs_q, hs_d, vs_q, vs_d;
  logic                        hs_raw, vs_raw, req_valid_w;
  logic [2:0]                  pipe_out;
  logic [3*CW-1:0]             win_pix;
  logic [CNT_W:0]              h_ext, v_ext;

  // Clock divider: tick fires on the clk where the divider wraps.
  always_comb begin
    tick_d = (div_q == DIV_LAST);
    div_d  = tick_d ? '0 : div_q + 1'b1;
  end

  // H/V counters, frame-start pulse and frame-latched layer enables.
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    frame_start_d = 1'b0;
    en_d          = en_q;
    if (tick_d) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    if (frame_start_d) begin
      en_d = layer_en;
    end
  end

  // Request-side decode of the current coordinate.
  always_comb begin
    h_ext       = {1'b0, h_q};
    v_ext       = {1'b0, v_q};
    req_valid_w = (h_ext < H_ACT_C) && (v_ext < V_ACT_C);
    hs_raw      = (h_ext >= HS_START_C) && (h_ext < HS_END_C);
    vs_raw      = (v_ext >= VS_START_C) && (v_ext < VS_END_C);
  end

  // Delay valid/sync flags by PIX_LAT ticks so they meet the returning layer pixel.
  always_comb begin
    pipe_d = pipe_q;
    if (tick_d) begin
      pipe_d[0] = {req_valid_w, hs_raw, vs_raw};
      for (int i = 1; i < PIX_LAT; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
    pipe_out = pipe_q[PIX_LAT-1];
  end

  // Priority resolve: the highest enabled, hitting layer wins.
  always_comb begin
    win_pix = BG_COLOR;
    for (int i = 0; i < NL; i++) begin
      if (layer_hit[i] && en_q[i]) begin
        win_pix = layer_pix[i*3*CW +: 3*CW];
      end
    end
  end

  // Output register: blanked colour plus polarity-applied syncs.
  always_comb begin
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (tick_d) begin
      rgb_d = pipe_out[2] ? win_pix : '0;
      hs_d  = pipe_out[1] ? HS_POL : ~HS_POL;
      vs_d  = pipe_out[0] ? VS_POL : ~VS_POL;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q         <= '0;
      pix_tick_q    <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      frame_start_q <= 1'b0;
      en_q          <= '0;
      pipe_q        <= '0;
      rgb_q         <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
    end else begin
      div_q         <= div_d;
      pix_tick_q    <= tick_d;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= frame_start_d;
      en_q          <= en_d;
      pipe_q        <= pipe_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
    end
  end

  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign req_valid   = req_valid_w;
  assign pix_tick    = pix_tick_q;
  assign frame_start = frame_start_q;
  assign vga_r       = rgb_q[3*CW-1 -: CW];
  assign vga_g       = rgb_q[2*CW-1 -: CW];
  assign vga_b       = rgb_q[CW-1:0];
  assign hsync       = hs_q;
  assign vsync       = vs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_display_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_vga_display_engine                                           |
// | Brief  : Scoreboard bench for vga_display_engine (reduced timing) plus a |
// |          second instance in the CLK_DIV=1 / PIX_LAT=1 / NL=3 corner.     |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_vga_display_engine;

  localparam int CLK_DIV = 2;
  localparam int PIX_LAT = 2;
  localparam int H_ACT = 16, H_FP = 2, H_SYNC = 3, H_BP = 2;
  localparam int V_ACT = 8,  V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int HT = 23, VT = 12;
  localparam int HS0 = 18, HS1 = 21, VS0 = 9, VS1 = 11;
  localparam logic [11:0] BG = 12'h125;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  layer_en = '0, layer_hit = '0;
  logic [23:0] layer_pix = '0;
  logic [9:0]  h_cnt, v_cnt;
  logic        req_valid, pix_tick, frame_start, hsync, vsync;
  logic [3:0]  vga_r, vga_g, vga_b;

  logic [2:0]  s_en = '0, s_hit = '0;
  logic [35:0] s_pix = '0;
  logic [3:0]  s_h, s_v, s_r, s_g, s_b;
  logic        s_req, s_tick, s_fs, s_hs, s_vs;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   sc      = 0;
  exp_t sb_q[$];
  int   mh, mv, mdiv;
  logic [1:0] men;
  int   hist_h [0:PIX_LAT];
  int   hist_v [0:PIX_LAT];
  bit   hist_ok[0:PIX_LAT];
  bit   m_tick, m_fs;
  exp_t m_e;

  always #5 clk = ~clk;

  vga_display_engine #(
    .CLK_DIV(CLK_DIV), .CW(4), .NL(2), .CNT_W(10),
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(PIX_LAT), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst), .layer_en(layer_en), .layer_hit(layer_hit), .layer_pix(layer_pix),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .req_valid(req_valid), .pix_tick(pix_tick),
    .frame_start(frame_start), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync)
  );

  vga_display_engine #(
    .CLK_DIV(1), .CW(4), .NL(3), .CNT_W(4),
    .H_ACT(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_LAT(1)
  ) dut_s (
    .clk(clk), .rst(rst), .layer_en(s_en), .layer_hit(s_hit), .layer_pix(s_pix),
    .h_cnt(s_h), .v_cnt(s_v), .req_valid(s_req), .pix_tick(s_tick),
    .frame_start(s_fs), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .hsync(s_hs), .vsync(s_vs)
  );

  // Layer sources: what each scenario returns for a requested coordinate.
  function automatic void layer_fn(input int s, input int x, input int y,
                                   output logic [1:0] hit, output logic [23:0] pix);
    hit = '0;
    pix = '0;
    case (s)
      1: if (x == 10 && y == 5) begin hit = 2'b01; pix[11:0] = 12'hF00; end
      2: begin hit = 2'b11; pix = {12'h00F, 12'h0F0}; end
      3: begin hit = 2'b11; pix = {12'hFFF, 12'hFFF}; end
      default: ;
    endcase
  endfunction

  // Reference output for a coordinate given the layer data and enables.
  function automatic exp_t expect_fn(input bit ok, input int x, input int y,
                                     input logic [1:0] hit, input logic [23:0] pix,
                                     input logic [1:0] en);
    exp_t e;
    e.rgb = '0;
    e.hs  = 1'b1;
    e.vs  = 1'b1;
    if (ok) begin
      if (x < H_ACT && y < V_ACT) begin
        if (hit[1] && en[1])      e.rgb = pix[23:12];
        else if (hit[0] && en[0]) e.rgb = pix[11:0];
        else                      e.rgb = BG;
      end
      e.hs = !(x >= HS0 && x < HS1);
      e.vs = !(y >= VS0 && y < VS1);
    end
    return e;
  endfunction

  // Present layer data for the request made PIX_LAT ticks ago and queue its expected output.
  function automatic void drive_layers();
    logic [1:0]  hit;
    logic [23:0] pix;
    hit = '0;
    pix = '0;
    if (hist_ok[PIX_LAT]) layer_fn(sc, hist_h[PIX_LAT], hist_v[PIX_LAT], hit, pix);
    layer_hit = hit;
    layer_pix = pix;
    sb_q.push_back(expect_fn(hist_ok[PIX_LAT], hist_h[PIX_LAT], hist_v[PIX_LAT], hit, pix, men));
  endfunction

  // Monitor: timing model, layer responder and scoreboard for the main instance.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      mh = 0; mv = 0; mdiv = 0; men = '0;
      sb_q.delete();
      for (int i = 0; i <= PIX_LAT; i++) hist_ok[i] = 1'b0;
      hist_ok[0] = 1'b1; hist_h[0] = 0; hist_v[0] = 0;
      drive_layers();
    end else begin
      mdiv++;
      m_tick = (mdiv == CLK_DIV);
      m_fs   = 1'b0;
      if (m_tick) mdiv = 0;
      n_tests++;
      if (pix_tick !== m_tick) begin
        n_fail++;
        $display("FAIL pix_tick: got %b, required %b at t=%0t", pix_tick, m_tick, $time);
      end
      if (m_tick) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty: no expected entry at t=%0t", $time);
        end else begin
          m_e = sb_q.pop_front();
          if ({vga_r, vga_g, vga_b} !== m_e.rgb || hsync !== m_e.hs || vsync !== m_e.vs) begin
            n_fail++;
            $display("FAIL sb_pixel: got rgb=%h hs=%b vs=%b, required rgb=%h hs=%b vs=%b (h=%0d v=%0d t=%0t)",
                     {vga_r, vga_g, vga_b}, hsync, vsync, m_e.rgb, m_e.hs, m_e.vs, mh, mv, $time);
          end
        end
        mh++;
        if (mh == HT) begin
          mh = 0; mv++;
          if (mv == VT) begin mv = 0; m_fs = 1'b1; end
        end
        if (m_fs) men = layer_en;
        n_tests++;
        if (h_cnt !== 10'(mh) || v_cnt !== 10'(mv) || req_valid !== (mh < H_ACT && mv < V_ACT)) begin
          n_fail++;
          $display("FAIL counters: got h=%0d v=%0d rv=%b, required h=%0d v=%0d rv=%b",
                   h_cnt, v_cnt, req_valid, mh, mv, (mh < H_ACT && mv < V_ACT));
        end
        for (int i = PIX_LAT; i > 0; i--) begin
          hist_h[i] = hist_h[i-1]; hist_v[i] = hist_v[i-1]; hist_ok[i] = hist_ok[i-1];
        end
        hist_h[0] = mh; hist_v[0] = mv; hist_ok[0] = 1'b1;
        drive_layers();
      end
      n_tests++;
      if (frame_start !== m_fs) begin
        n_fail++;
        $display("FAIL frame_start: got %b, required %b at t=%0t", frame_start, m_fs, $time);
      end
    end
  end

  task automatic next_tick(output bit ok);
    int c;
    c = 0;
    do begin @(posedge clk); #2; c++; end while (pix_tick !== 1'b1 && c < 100);
    ok = (pix_tick === 1'b1);
  endtask

  task automatic wait_frame_start(output bit ok);
    int c;
    c = 0;
    do begin @(posedge clk); #2; c++; end while (frame_start !== 1'b1 && c < 2000);
    ok = (frame_start === 1'b1);
  endtask

  task automatic wait_coord(input int x, input int y, output bit ok);
    int c;
    c = 0;
    do begin @(posedge clk); #2; c++; end
    while (!(pix_tick === 1'b1 && h_cnt == 10'(x) && v_cnt == 10'(y)) && c < 2000);
    ok = (pix_tick === 1'b1 && h_cnt == 10'(x) && v_cnt == 10'(y));
  endtask

  task automatic skip_ticks(input int n, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      bit k;
      next_tick(k);
      ok &= k;
    end
  endtask

  task automatic test_reset();
    bit ok;
    int c;
    rst = 1'b0;
    #23;
    n_tests++;
    if (h_cnt !== 0 || v_cnt !== 0 || pix_tick !== 0 || frame_start !== 0 ||
        {vga_r, vga_g, vga_b} !== 0 || hsync !== 1 || vsync !== 1 || req_valid !== 1) begin
      n_fail++;
      $display("FAIL reset_state: got h=%0d v=%0d tick=%b fs=%b rgb=%h hs=%b vs=%b rv=%b, required 0/0/0/0/000/1/1/1",
               h_cnt, v_cnt, pix_tick, frame_start, {vga_r, vga_g, vga_b}, hsync, vsync, req_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    wait_frame_start(ok);
    c = 0;
    do begin @(posedge clk); #2; c++; end while (frame_start !== 1'b1 && c < 2000);
    n_tests++;
    if (!ok || c != HT * VT * CLK_DIV) begin
      n_fail++;
      $display("FAIL frame_period: got %0d clks (first seen=%b), required %0d", c, ok, HT * VT * CLK_DIV);
    end
    c = 0;
    do begin next_tick(ok); c++; end while (hsync !== 1'b0 && c < 100);
    n_tests++;
    if (hsync !== 1'b0 || h_cnt != 10'((HS0 + PIX_LAT + 1) % HT)) begin
      n_fail++;
      $display("FAIL hsync_start: got hs=%b at h=%0d, required hs=0 at h=%0d", hsync, h_cnt, (HS0 + PIX_LAT + 1) % HT);
    end
    c = 0;
    while (hsync === 1'b0 && c < 50) begin c++; next_tick(ok); end
    n_tests++;
    if (c != H_SYNC) begin
      n_fail++;
      $display("FAIL hsync_width: got %0d ticks, required %0d", c, H_SYNC);
    end
  endtask

  task automatic test_alignment();
    bit ok, ok2;
    logic [11:0] got2, got3, got4;
    sc = 1;
    layer_en = 2'b01;
    wait_frame_start(ok);
    wait_coord(10, 5, ok2);
    ok &= ok2;
    skip_ticks(2, ok2); ok &= ok2; got2 = {vga_r, vga_g, vga_b};
    skip_ticks(1, ok2); ok &= ok2; got3 = {vga_r, vga_g, vga_b};
    skip_ticks(1, ok2); ok &= ok2; got4 = {vga_r, vga_g, vga_b};
    n_tests++;
    if (!ok || got3 !== 12'hF00) begin
      n_fail++;
      $display("FAIL align_hit: got %h (waits ok=%b), required F00", got3, ok);
    end
    n_tests++;
    if (got2 !== BG || got4 !== BG) begin
      n_fail++;
      $display("FAIL align_neighbours: got %h/%h, required %h/%h", got2, got4, BG, BG);
    end
  endtask

  task automatic test_priority();
    bit ok, ok2;
    sc = 2;
    layer_en = 2'b11;
    wait_frame_start(ok);
    wait_coord(5, 2, ok2); ok &= ok2;
    skip_ticks(PIX_LAT + 1, ok2); ok &= ok2;
    n_tests++;
    if (!ok || {vga_r, vga_g, vga_b} !== 12'h00F) begin
      n_fail++;
      $display("FAIL prio_both: got %h, required 00F", {vga_r, vga_g, vga_b});
    end
    @(negedge clk);
    layer_en = 2'b01;
    wait_coord(5, 6, ok); 
    skip_ticks(PIX_LAT + 1, ok2); ok &= ok2;
    n_tests++;
    if (!ok || {vga_r, vga_g, vga_b} !== 12'h00F) begin
      n_fail++;
      $display("FAIL prio_midframe_en: got %h, required 00F", {vga_r, vga_g, vga_b});
    end
    wait_frame_start(ok);
    wait_coord(5, 2, ok2); ok &= ok2;
    skip_ticks(PIX_LAT + 1, ok2); ok &= ok2;
    n_tests++;
    if (!ok || {vga_r, vga_g, vga_b} !== 12'h0F0) begin
      n_fail++;
      $display("FAIL prio_next_frame: got %h, required 0F0", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_blanking();
    bit ok, ok2;
    int n_full, n_zero;
    sc = 3;
    layer_en = 2'b11;
    wait_frame_start(ok);
    skip_ticks(PIX_LAT + 1, ok2); ok &= ok2;
    n_full = 0; n_zero = 0;
    for (int i = 0; i < HT * VT; i++) begin
      if ({vga_r, vga_g, vga_b} === 12'hFFF) n_full++;
      if ({vga_r, vga_g, vga_b} === 12'h000) n_zero++;
      if (i < HT * VT - 1) begin next_tick(ok2); ok &= ok2; end
    end
    n_tests++;
    if (!ok || n_full != H_ACT * V_ACT) begin
      n_fail++;
      $display("FAIL blank_visible: got %0d FFF ticks, required %0d", n_full, H_ACT * V_ACT);
    end
    n_tests++;
    if (n_zero != HT * VT - H_ACT * V_ACT) begin
      n_fail++;
      $display("FAIL blank_porch: got %0d zero ticks, required %0d", n_zero, HT * VT - H_ACT * V_ACT);
    end
  endtask

  task automatic test_reset_midline();
    bit ok;
    int c;
    logic [11:0] pre;
    sc = 3;
    wait_coord(12, 3, ok);
    pre = {vga_r, vga_g, vga_b};
    #1;
    rst = 1'b0;
    #1;
    n_tests++;
    if (!ok || pre !== 12'hFFF || h_cnt !== 0 || v_cnt !== 0 || {vga_r, vga_g, vga_b} !== 0 ||
        hsync !== 1 || vsync !== 1 || pix_tick !== 0 || frame_start !== 0) begin
      n_fail++;
      $display("FAIL async_reset: got pre=%h h=%0d v=%0d rgb=%h hs=%b vs=%b tick=%b fs=%b, required FFF 0 0 000 1 1 0 0",
               pre, h_cnt, v_cnt, {vga_r, vga_g, vga_b}, hsync, vsync, pix_tick, frame_start);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    c = 0;
    do begin
      @(posedge clk); #2; c++;
      if (c == CLK_DIV) begin
        n_tests++;
        if (pix_tick !== 1 || h_cnt !== 1 || v_cnt !== 0) begin
          n_fail++;
          $display("FAIL restart_first_tick: got tick=%b h=%0d v=%0d, required 1 1 0", pix_tick, h_cnt, v_cnt);
        end
      end
    end while (frame_start !== 1'b1 && c < 2000);
    n_tests++;
    if (c != HT * VT * CLK_DIV) begin
      n_fail++;
      $display("FAIL restart_frame_start: got first frame_start after %0d clks, required %0d", c, HT * VT * CLK_DIV);
    end
  endtask

  task automatic test_small_config();
    int c, n_hi;
    s_hit = 3'b111;
    s_pix = {12'h333, 12'h222, 12'h111};
    s_en  = 3'b111;
    n_hi = 0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #2; if (s_tick === 1'b1) n_hi++; end
    n_tests++;
    if (n_hi != 10) begin
      n_fail++;
      $display("FAIL small_tick: got %0d ticks in 10 clks, required 10", n_hi);
    end
    c = 0;
    do begin @(posedge clk); #2; c++; end while (s_fs !== 1'b1 && c < 500);
    c = 0;
    do begin @(posedge clk); #2; c++; end while (s_fs !== 1'b1 && c < 500);
    n_tests++;
    if (c != 12 * 7) begin
      n_fail++;
      $display("FAIL small_frame: got %0d clks, required %0d", c, 12 * 7);
    end
    @(posedge clk); #2;
    n_tests++;
    if ({s_r, s_g, s_b} !== 12'h000) begin
      n_fail++;
      $display("FAIL small_blank: got %h, required 000", {s_r, s_g, s_b});
    end
    @(posedge clk); #2;
    n_tests++;
    if ({s_r, s_g, s_b} !== 12'h333) begin
      n_fail++;
      $display("FAIL small_l2_wins: got %h, required 333", {s_r, s_g, s_b});
    end
    s_en = 3'b011;
    c = 0;
    do begin @(posedge clk); #2; c++; end while (s_fs !== 1'b1 && c < 500);
    repeat (2) begin @(posedge clk); #2; end
    n_tests++;
    if ({s_r, s_g, s_b} !== 12'h222) begin
      n_fail++;
      $display("FAIL small_l1_wins: got %h, required 222", {s_r, s_g, s_b});
    end
  endtask

  initial begin
    test_reset();
    test_alignment();
    test_priority();
    test_blanking();
    test_reset_midline();
    test_small_config();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
